// File: rtl/match_flow_controller.sv
// Match sequencing for a two-player fighting game: menu, countdown, play,
// pause, round-over hold and match-over, with round-win bookkeeping.
module match_flow_controller #(
    parameter int unsigned TICKS_PER_SEC    = 60,
    parameter int unsigned COUNT_SECS       = 3,
    parameter int unsigned ROUNDS_TO_WIN    = 2,
    parameter int unsigned ROUND_OVER_TICKS = 120,
    parameter int unsigned PAUSE_EN         = 1
) (
    input  logic                                 clk_game,
    input  logic                                 reset_n,
    input  logic                                 confirm_btn,
    input  logic                                 pause_btn,
    input  logic                                 sw_mode_2p,
    input  logic                                 round_over,
    input  logic                                 round_winner,
    output logic [2:0]                           game_state,
    output logic [3:0]                           countdown_digit,
    output logic                                 mode_1p,
    output logic [$clog2(ROUNDS_TO_WIN+1)-1:0]   p1_wins,
    output logic [$clog2(ROUNDS_TO_WIN+1)-1:0]   p2_wins,
    output logic                                 match_winner,
    output logic                                 start_round,
    output logic                                 reset_round,
    output logic                                 timer_enable,
    output logic                                 timer_reset
);

    localparam int unsigned CD_LOAD = TICKS_PER_SEC * COUNT_SECS;
    localparam int unsigned CNT_W   = $clog2(CD_LOAD + 1);
    localparam int unsigned RO_W    = $clog2(ROUND_OVER_TICKS + 1);
    localparam int unsigned WIN_W   = $clog2(ROUNDS_TO_WIN + 1);

    localparam logic [CNT_W-1:0] CD_LOAD_V = CNT_W'(CD_LOAD);
    localparam logic [RO_W-1:0]  RO_LAST   = RO_W'(ROUND_OVER_TICKS - 1);
    localparam logic [WIN_W-1:0] WIN_MAX   = WIN_W'(ROUNDS_TO_WIN);
    localparam logic [WIN_W-1:0] WIN_ONE   = WIN_W'(1);

    typedef enum logic [2:0] {
        S_MENU       = 3'd0,
        S_COUNTDOWN  = 3'd1,
        S_PLAY       = 3'd2,
        S_ROUND_OVER = 3'd3,
        S_PAUSE      = 3'd4,
        S_MATCH_OVER = 3'd5
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cd_cnt_q, cd_cnt_d;
    logic [RO_W-1:0]   ro_cnt_q, ro_cnt_d;
    logic              conf_prev_q, conf_prev_d;
    logic              conf_arm_q, conf_arm_d;
    logic              pause_prev_q, pause_prev_d;
    logic              pause_arm_q, pause_arm_d;
    logic [WIN_W-1:0]  p1_wins_q, p1_wins_d;
    logic [WIN_W-1:0]  p2_wins_q, p2_wins_d;
    logic              mode_1p_q, mode_1p_d;
    logic              match_winner_q, match_winner_d;
    logic              start_round_q, start_round_d;
    logic              reset_round_q, reset_round_d;
    logic              timer_enable_q, timer_enable_d;
    logic              timer_reset_q, timer_reset_d;
    logic [3:0]        digit_q, digit_d;
    logic              conf_e, pause_e;

    always_comb begin
        // The arm flag stays low until a released button is seen, so a
        // button held through reset release never counts as a press.
        conf_e         = confirm_btn & ~conf_prev_q & conf_arm_q;
        pause_e        = pause_btn & ~pause_prev_q & pause_arm_q;
        conf_prev_d    = confirm_btn;
        pause_prev_d   = pause_btn;
        conf_arm_d     = conf_arm_q | ~confirm_btn;
        pause_arm_d    = pause_arm_q | ~pause_btn;

        state_d        = state_q;
        cd_cnt_d       = cd_cnt_q;
        ro_cnt_d       = ro_cnt_q;
        p1_wins_d      = p1_wins_q;
        p2_wins_d      = p2_wins_q;
        mode_1p_d      = mode_1p_q;
        match_winner_d = match_winner_q;
        start_round_d  = 1'b0;

        case (state_q)
            S_MENU: begin
                if (conf_e) begin
                    mode_1p_d      = ~sw_mode_2p;
                    p1_wins_d      = '0;
                    p2_wins_d      = '0;
                    match_winner_d = 1'b0;
                    cd_cnt_d       = CD_LOAD_V;
                    state_d        = S_COUNTDOWN;
                end
            end
            S_COUNTDOWN: begin
                if (cd_cnt_q == '0) begin
                    start_round_d = 1'b1;
                    state_d       = S_PLAY;
                end else begin
                    cd_cnt_d = cd_cnt_q - CNT_W'(1);
                end
            end
            S_PLAY: begin
                if (round_over) begin
                    if (!round_winner && p1_wins_q != WIN_MAX) p1_wins_d = p1_wins_q + WIN_ONE;
                    if (round_winner && p2_wins_q != WIN_MAX)  p2_wins_d = p2_wins_q + WIN_ONE;
                    ro_cnt_d = RO_LAST;
                    state_d  = S_ROUND_OVER;
                end else if (pause_e && PAUSE_EN != 0) begin
                    state_d = S_PAUSE;
                end
            end
            S_PAUSE: begin
                if (pause_e || conf_e) state_d = S_PLAY;
            end
            S_ROUND_OVER: begin
                if (ro_cnt_q == '0) begin
                    if (p1_wins_q == WIN_MAX || p2_wins_q == WIN_MAX) begin
                        match_winner_d = (p2_wins_q == WIN_MAX);
                        state_d        = S_MATCH_OVER;
                    end else begin
                        cd_cnt_d = CD_LOAD_V;
                        state_d  = S_COUNTDOWN;
                    end
                end else begin
                    ro_cnt_d = ro_cnt_q - RO_W'(1);
                end
            end
            S_MATCH_OVER: begin
                if (conf_e) state_d = S_MENU;
            end
            default: state_d = S_MENU;
        endcase

        // Outputs are decoded from the next state so they register alongside it.
        timer_enable_d = (state_d == S_PLAY);
        timer_reset_d  = (state_d == S_MENU) ||
                         (state_d == S_COUNTDOWN && state_q != S_COUNTDOWN);
        reset_round_d  = (state_d == S_MENU) || (state_d == S_COUNTDOWN) ||
                         (state_d == S_ROUND_OVER);
        if (state_d == S_COUNTDOWN)
            digit_d = 4'((32'(cd_cnt_d) + TICKS_PER_SEC - 1) / TICKS_PER_SEC);
        else
            digit_d = 4'd15;
    end

    always_ff @(posedge clk_game or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= S_MENU;
            cd_cnt_q       <= '0;
            ro_cnt_q       <= '0;
            conf_prev_q    <= 1'b0;
            conf_arm_q     <= 1'b0;
            pause_prev_q   <= 1'b0;
            pause_arm_q    <= 1'b0;
            p1_wins_q      <= '0;
            p2_wins_q      <= '0;
            mode_1p_q      <= 1'b0;
            match_winner_q <= 1'b0;
            start_round_q  <= 1'b0;
            reset_round_q  <= 1'b1;
            timer_enable_q <= 1'b0;
            timer_reset_q  <= 1'b1;
            digit_q        <= 4'd15;
        end else begin
            state_q        <= state_d;
            cd_cnt_q       <= cd_cnt_d;
            ro_cnt_q       <= ro_cnt_d;
            conf_prev_q    <= conf_prev_d;
            conf_arm_q     <= conf_arm_d;
            pause_prev_q   <= pause_prev_d;
            pause_arm_q    <= pause_arm_d;
            p1_wins_q      <= p1_wins_d;
            p2_wins_q      <= p2_wins_d;
            mode_1p_q      <= mode_1p_d;
            match_winner_q <= match_winner_d;
            start_round_q  <= start_round_d;
            reset_round_q  <= reset_round_d;
            timer_enable_q <= timer_enable_d;
            timer_reset_q  <= timer_reset_d;
            digit_q        <= digit_d;
        end
    end

    assign game_state      = state_q;
    assign countdown_digit = digit_q;
    assign mode_1p         = mode_1p_q;
    assign p1_wins         = p1_wins_q;
    assign p2_wins         = p2_wins_q;
    assign match_winner    = match_winner_q;
    assign start_round     = start_round_q;
    assign reset_round     = reset_round_q;
    assign timer_enable    = timer_enable_q;
    assign timer_reset     = timer_reset_q;

endmodule

// File: tb/tb_match_flow_controller.sv
// Randomised bench for match_flow_controller: a phase/elapsed-time model
// predicts every cycle's outputs into queues that a monitor drains.
module tb_match_flow_controller;

    localparam int TPS = 60;
    localparam int CS  = 3;
    localparam int RTW = 2;
    localparam int ROT = 120;

    localparam int P_MENU = 0, P_CD = 1, P_PLAY = 2, P_RO = 3, P_PAUSE = 4, P_MO = 5;

    logic clk_game = 1'b0;
    always #5 clk_game = ~clk_game;

    logic reset_n = 1'b0;
    logic confirm_btn = 1'b0, pause_btn = 1'b0, sw_mode_2p = 1'b0;
    logic round_over = 1'b0, round_winner = 1'b0;

    logic [2:0] a_state, b_state;
    logic [3:0] a_digit, b_digit;
    logic       a_mode, b_mode, a_win, b_win, a_sr, b_sr, a_rr, b_rr, a_te, b_te, a_tr, b_tr;
    logic [1:0] a_p1, a_p2, b_p1, b_p2;

    match_flow_controller #(.TICKS_PER_SEC(TPS), .COUNT_SECS(CS), .ROUNDS_TO_WIN(RTW),
                            .ROUND_OVER_TICKS(ROT), .PAUSE_EN(1)) dut_a (
        .clk_game(clk_game), .reset_n(reset_n), .confirm_btn(confirm_btn),
        .pause_btn(pause_btn), .sw_mode_2p(sw_mode_2p), .round_over(round_over),
        .round_winner(round_winner), .game_state(a_state), .countdown_digit(a_digit),
        .mode_1p(a_mode), .p1_wins(a_p1), .p2_wins(a_p2), .match_winner(a_win),
        .start_round(a_sr), .reset_round(a_rr), .timer_enable(a_te), .timer_reset(a_tr));

    match_flow_controller #(.TICKS_PER_SEC(TPS), .COUNT_SECS(CS), .ROUNDS_TO_WIN(RTW),
                            .ROUND_OVER_TICKS(ROT), .PAUSE_EN(0)) dut_b (
        .clk_game(clk_game), .reset_n(reset_n), .confirm_btn(confirm_btn),
        .pause_btn(pause_btn), .sw_mode_2p(sw_mode_2p), .round_over(round_over),
        .round_winner(round_winner), .game_state(b_state), .countdown_digit(b_digit),
        .mode_1p(b_mode), .p1_wins(b_p1), .p2_wins(b_p2), .match_winner(b_win),
        .start_round(b_sr), .reset_round(b_rr), .timer_enable(b_te), .timer_reset(b_tr));

    typedef struct {
        int phase; int elapsed; bit mode; int p1; int p2; bit winner; bit start;
        bit cprev; bit carm; bit pprev; bit parm;
    } model_t;

    typedef struct {
        int st; int dig; bit mode; int p1; int p2; bit win; bit sr; bit rr; bit te; bit tr;
    } exp_t;

    model_t ma, mb;
    exp_t   qa[$], qb[$];
    int     n_checks = 0, n_pass = 0;

    function automatic void chk(string name, int act, int exp_v);
        n_checks++;
        if (act == exp_v) n_pass++;
        else $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp_v, $time);
    endfunction

    function automatic model_t model_reset();
        model_t m;
        m = '{phase: P_MENU, elapsed: 0, mode: 0, p1: 0, p2: 0, winner: 0, start: 0,
              cprev: 0, carm: 0, pprev: 0, parm: 0};
        return m;
    endfunction

    function automatic model_t step(model_t m, bit pen, bit conf, bit pau, bit sw, bit ro, bit rw);
        model_t n;
        bit ce, pe;
        n = m;
        ce = conf && !m.cprev && m.carm;
        pe = pau && !m.pprev && m.parm;
        n.cprev = conf; n.carm = m.carm || !conf;
        n.pprev = pau;  n.parm = m.parm || !pau;
        n.start = 0;
        case (m.phase)
            P_MENU: if (ce) begin
                n.phase = P_CD; n.elapsed = 0; n.mode = !sw; n.p1 = 0; n.p2 = 0; n.winner = 0;
            end
            P_CD: if (m.elapsed == TPS * CS) begin
                n.phase = P_PLAY; n.start = 1;
            end else n.elapsed = m.elapsed + 1;
            P_PLAY: if (ro) begin
                if (!rw) n.p1 = (m.p1 + 1 > RTW) ? RTW : m.p1 + 1;
                else     n.p2 = (m.p2 + 1 > RTW) ? RTW : m.p2 + 1;
                n.phase = P_RO; n.elapsed = 0;
            end else if (pe && pen) n.phase = P_PAUSE;
            P_PAUSE: if (pe || ce) n.phase = P_PLAY;
            P_RO: if (m.elapsed == ROT - 1) begin
                if (m.p1 == RTW || m.p2 == RTW) begin
                    n.phase = P_MO; n.winner = (m.p2 == RTW);
                end else begin
                    n.phase = P_CD; n.elapsed = 0;
                end
            end else n.elapsed = m.elapsed + 1;
            P_MO: if (ce) n.phase = P_MENU;
            default: n.phase = P_MENU;
        endcase
        return n;
    endfunction

    function automatic exp_t expect_of(model_t m);
        exp_t e;
        e.st   = m.phase;
        e.dig  = (m.phase != P_CD) ? 15 : (m.elapsed == TPS * CS) ? 0 : CS - m.elapsed / TPS;
        e.mode = m.mode; e.p1 = m.p1; e.p2 = m.p2; e.win = m.winner; e.sr = m.start;
        e.rr   = (m.phase == P_MENU || m.phase == P_CD || m.phase == P_RO);
        e.te   = (m.phase == P_PLAY);
        e.tr   = (m.phase == P_MENU) || (m.phase == P_CD && m.elapsed == 0);
        return e;
    endfunction

    // Called right after a falling edge: set inputs, predict the next rising edge.
    task automatic apply(bit conf, bit pau, bit sw, bit ro, bit rw);
        confirm_btn = conf; pause_btn = pau; sw_mode_2p = sw; round_over = ro; round_winner = rw;
        ma = step(ma, 1'b1, conf, pau, sw, ro, rw);
        mb = step(mb, 1'b0, conf, pau, sw, ro, rw);
        qa.push_back(expect_of(ma));
        qb.push_back(expect_of(mb));
    endtask

    task automatic drive(bit conf, bit pau, bit sw, bit ro, bit rw);
        @(negedge clk_game);
        apply(conf, pau, sw, ro, rw);
    endtask

    task automatic do_reset(int cycles, bit conf_hold);
        @(negedge clk_game);
        confirm_btn = conf_hold; pause_btn = 1'b0; round_over = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("async_rst_state_a", a_state, P_MENU);
        chk("async_rst_digit_a", a_digit, 15);
        chk("async_rst_start_a", a_sr, 0);
        chk("async_rst_state_b", b_state, P_MENU);
        ma = model_reset(); mb = model_reset();
        qa.push_back(expect_of(ma)); qb.push_back(expect_of(mb));
        for (int i = 1; i < cycles; i++) begin
            @(negedge clk_game);
            qa.push_back(expect_of(ma)); qb.push_back(expect_of(mb));
        end
        @(negedge clk_game);
        reset_n = 1'b1;
        apply(conf_hold, 1'b0, sw_mode_2p, 1'b0, 1'b0);
    endtask

    task automatic compare(string t, exp_t e, int st, int dig, bit mode, int p1, int p2,
                           bit win, bit sr, bit rr, bit te, bit tr);
        chk({t, "_state"}, st, e.st);
        chk({t, "_digit"}, dig, e.dig);
        chk({t, "_mode_1p"}, mode, e.mode);
        chk({t, "_p1_wins"}, p1, e.p1);
        chk({t, "_p2_wins"}, p2, e.p2);
        chk({t, "_match_winner"}, win, e.win);
        chk({t, "_start_round"}, sr, e.sr);
        chk({t, "_reset_round"}, rr, e.rr);
        chk({t, "_timer_enable"}, te, e.te);
        chk({t, "_timer_reset"}, tr, e.tr);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk_game);
            #1;
            if (qa.size() > 0) begin
                e = qa.pop_front();
                compare("A", e, a_state, a_digit, a_mode, a_p1, a_p2, a_win, a_sr, a_rr, a_te, a_tr);
            end
            if (qb.size() > 0) begin
                e = qb.pop_front();
                compare("B", e, b_state, b_digit, b_mode, b_p1, b_p2, b_win, b_sr, b_rr, b_te, b_tr);
            end
        end
    end

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench timed out");
    end

    initial begin : driver
        bit c_lvl, p_lvl, ro, rw;
        ma = model_reset(); mb = model_reset();
        do_reset(3, 1'b0);

        // 2P selected at start, then countdown interrupted by reset at digit 2
        // with confirm held through the release.
        drive(0, 0, 1, 0, 0);
        drive(1, 0, 1, 0, 0);
        for (int i = 0; i < 70; i++) drive(1, 0, $urandom_range(0, 1), 0, 0);
        chk("pre_reset_digit_2", a_digit, 2);
        do_reset(2, 1'b1);
        for (int i = 0; i < 10; i++) drive(1, 0, 0, 0, 0);
        chk("held_conf_stays_menu", a_state, P_MENU);
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);

        c_lvl = 1'b1; p_lvl = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            if ($urandom_range(0, 3) == 0) c_lvl = ~c_lvl;
            if ($urandom_range(0, 7) == 0) p_lvl = ~p_lvl;
            rw = 1'($urandom_range(0, 1));
            if (ma.phase == P_PLAY) begin
                ro = ($urandom_range(0, 49) == 0);
                if ($urandom_range(0, 39) == 0) begin
                    ro = 1'b1; p_lvl = 1'b1;
                end
            end else begin
                ro = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 3999) == 0) begin
                do_reset($urandom_range(1, 3), c_lvl);
            end else begin
                drive(c_lvl, p_lvl, 1'($urandom_range(0, 1)), ro, rw);
            end
        end

        @(negedge clk_game);
        @(negedge clk_game);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
